// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (req0 wins) otherwise.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [WIDTH-1:0] resp_res,
   output logic             resp_cond,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_cond
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic gnt_id, sel1, resp_hs, accept_en, req_hs;
   logic [WIDTH-1:0] res_r;
   logic cond_r;
`ifdef ALU_ARB_RR_EN
   logic last_gnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_gnt <= 1'b1;
      else if (req_hs) last_gnt <= sel1;
   assign sel1 = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
`else
   assign sel1 = ~req0_valid & req1_valid;
`endif
   // a new request may overlap the response handshake of the previous one
   assign resp_hs = (state == RESP) & (gnt_id ? resp1_ready : resp0_ready);
   assign accept_en = rst_n & ((state == IDLE) | resp_hs);
   assign req0_ready = accept_en & req0_valid & ~sel1;
   assign req1_ready = accept_en & req1_valid & sel1;
   assign req_hs = req0_ready | req1_ready;
   assign resp0_valid = (state == RESP) & ~gnt_id;
   assign resp1_valid = (state == RESP) & gnt_id;
   assign resp_res = res_r;
   assign resp_cond = cond_r;
   always_comb begin
      state_nx = (state == EXEC) ? RESP :
                 ((state == RESP) & ~resp_hs) ? RESP :
                 req_hs ? EXEC : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         gnt_id <= 1'b0;
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         res_r  <= '0;
         cond_r <= 1'b0;
      end else begin
         state <= state_nx;
         if (req_hs) begin
            gnt_id <= sel1;
            alu_op <= sel1 ? req1_op : req0_op;
            alu_a  <= sel1 ? req1_a : req0_a;
            alu_b  <= sel1 ? req1_b : req0_b;
         end
         if (state == EXEC) begin
            res_r  <= alu_res;
            cond_r <= alu_cond;
         end
      end
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer ALU between two requesters (execute-stage integer path and branch-resolution path) using valid/ready handshakes. It accepts one operation at a time and drives the ALU from a registered operand stage. It captures the ALU `res`/`cond` into a result register and returns them to the winning requester. Sits between the pipeline control and the ALU instance; the ALU itself stays purely combinational.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width; must match the ALU.

Ports:
- `clk` (in, 1): single clock, rising edge.
- `rst_n` (in, 1): reset, asynchronous and active-low.
- `req0_valid`, `req1_valid` (in, 1): request present.
- `req0_ready`, `req1_ready` (out, 1): request accepted this cycle.
- `req0_op`, `req1_op` (in, 4): ALU opcode, encodings from the shared codes header.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` (in, WIDTH): operands.
- `resp0_valid`, `resp1_valid` (out, 1): result available for that requester.
- `resp0_ready`, `resp1_ready` (in, 1): requester consumes the result.
- `resp_res` (out, WIDTH): result, shared by both response channels.
- `resp_cond` (out, 1): condition, shared by both response channels.
- `alu_op` (out, 4): registered opcode driven to the ALU.
- `alu_a`, `alu_b` (out, WIDTH): registered operands driven to the ALU.
- `alu_res` (in, WIDTH): ALU result.
- `alu_cond` (in, 1): ALU condition.

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- Request acceptance:
  - Acceptance is possible in IDLE, and in RESP during the cycle its response handshake completes.
  - The grant picks one valid requester. Only the granted requester sees `reqN_ready`=1. Ready is combinational from valid and state.
  - Handshake = valid & ready. It latches op/a/b into the operand register and the grant id into `gnt_id`, then moves to EXEC.
- EXEC (exactly 1 cycle):
  - `alu_*` reflect the operand register.
  - At the clock edge, `alu_res` and `alu_cond` are captured into the result register.
  - The FSM moves to RESP.
- RESP:
  - `resp<gnt_id>_valid`=1; the other response valid stays 0.
  - `resp_res` and `resp_cond` hold the captured values.
  - The state is held until `resp<gnt_id>_ready`=1.
  - On handshake, the FSM moves to EXEC if a new request was accepted in the same cycle, otherwise to IDLE.
- Requester rules:
  - Requesters must hold valid/op/a/b stable until ready.
  - The arbiter never drops an accepted request.
- Grant policy:
  - Fixed priority: req0 always wins ties.
  - Round-robin variant: see Configuration.
- Width rules:
  - No arithmetic is done in this block; values pass through unmodified.
  - An undefined opcode is forwarded as-is; the ALU's 0 output is returned normally.
- Response outputs outside RESP:
  - Both `respN_valid`=0.
  - `resp_res` and `resp_cond` hold their last captured value and must not be interpreted.

## Timing

- Reset values:
  - State IDLE; `req*_ready`=0 while `rst_n`=0.
  - `resp*_valid`=0.
  - `resp_res`=0, `resp_cond`=0.
  - `alu_op`=0, `alu_a`=0, `alu_b`=0.
  - Round-robin pointer `last_gnt`=1, so req0 wins first.
- Latency: request handshake at cycle N; EXEC in N+1; `resp_valid` from N+2.
- Throughput: one operation per 2 cycles when responses are consumed immediately, since accept overlaps the RESP handshake.
- Response stall: `resp_ready`=0 keeps `resp_valid`, `resp_res` and `resp_cond` stable indefinitely. No new request is accepted meanwhile (both `req*_ready`=0).
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded, all outputs go to reset values immediately (asynchronous), and the result is not delivered.
- Simultaneous valid on both requesters: exactly one ready per cycle, never both.

## Configuration

- `ALU_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, the requester that is not `last_gnt` wins.
  - `last_gnt` updates on every request handshake.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority: req0 always wins.
  - `last_gnt` is not implemented.

## Test plan

- req0 ADD a=5 b=7, resp0_ready=1 -> resp0_valid at handshake+2, resp_res=12, resp_cond=0, resp1_valid=0 throughout.
- req1 LT a=0xFFFFFFFF b=1 -> resp1_valid with resp_cond=1. Repeat with LTU -> resp_cond=0.
- Both valid continuously, 4 ops each, resp ready=1:
  - RR on: grants alternate 0,1,0,1…
  - RR off: all req0 ops complete before any req1 op.
  - Back-to-back ops start every 2 cycles.
- req0 SUB 3-5, resp0_ready held 0 for 5 cycles -> resp0_valid and resp_res=0xFFFFFFFE stable; req1_ready=0 while req1_valid=1; release -> req1 accepted in the same cycle.
- rst_n pulsed low during EXEC of req0 ADD -> all outputs at reset values asynchronously; no resp0_valid afterwards; the next request completes normally.
